// File: rtl/fifth_code_loader.sv
// fifth_code_loader: program memory and byte-stream loader for the fifth CPU.
// A frame is A5, LEN_HI, LEN_LO, N big-endian words and, when
// FIFTH_LOADER_CHECKSUM_EN is defined, one checksum byte. While a frame is
// loading the CPU is held in reset. In RUN the CPU is released and fetches
// are served with one cycle of read latency.
// Ports:
//   clk, reset (async, active low)
//   rx_data/rx_valid/rx_ready : byte stream in (valid/ready handshake)
//   reload                    : level request to abort or restart loading
//   code_addr/instruction     : fetch port, instruction = mem[code_addr] one cycle later
//   cpu_reset_n, load_done    : high while a loaded program is running
//   load_error                : sticky bad-frame flag, cleared by the next header
// Macro: FIFTH_LOADER_CHECKSUM_EN enables the CHK state and the checksum.
module fifth_code_loader #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] code_addr,
  output logic [15:0]       instruction,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error
);
  localparam int CW = ADDR_W + 1;

  localparam logic [2:0] S_HDR    = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_D_HI   = 3'd3;
  localparam logic [2:0] S_D_LO   = 3'd4;
`ifdef FIFTH_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd5;
`endif
  localparam logic [2:0] S_RUN    = 3'd6;

  logic [2:0]        state;
  logic [7:0]        len_hi;
  logic [7:0]        data_hi;
  logic [CW-1:0]     len;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     wcnt_nxt;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       frame_len;
  logic              bad_len;
  logic              accept;
  logic              last_word;
  logic              mem_we;
  logic              running;
`ifdef FIFTH_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic [15:0] mem [2**ADDR_W];

  assign rx_ready  = (state != S_RUN) && !reload;
  assign accept    = rx_valid && rx_ready;
  assign frame_len = {len_hi, rx_data};
  // Exactly 2^ADDR_W words is legal; the address then ends on the top word.
  assign bad_len   = (frame_len == 16'd0) || (32'(frame_len) > (32'd1 << ADDR_W));
  assign wcnt_nxt  = wcnt + 1'b1;
  assign last_word = (wcnt_nxt == len);
  assign mem_we    = accept && (state == S_D_LO);

  // One flop drives both run indicators so they move on the same edge.
  assign cpu_reset_n = running;
  assign load_done   = running;

  // Memory has no reset; contents survive reset and aborted frames.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= {data_hi, rx_data};
  end

  // Read-first: a same-cycle write to code_addr is seen one fetch later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instruction <= 16'h0000;
    else        instruction <= mem[code_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HDR;
      len_hi     <= 8'h00;
      data_hi    <= 8'h00;
      len        <= '0;
      wcnt       <= '0;
      waddr      <= '0;
      running    <= 1'b0;
      load_error <= 1'b0;
`ifdef FIFTH_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else if (reload) begin
      // Abort or restart; load_error is deliberately left alone.
      state   <= S_HDR;
      running <= 1'b0;
    end else if (accept) begin
      case (state)
        S_HDR: begin
          if (rx_data == 8'hA5) begin
            state      <= S_LEN_HI;
            load_error <= 1'b0;
            wcnt       <= '0;
            waddr      <= '0;
`ifdef FIFTH_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
          end
        end
        S_LEN_HI: begin
          len_hi <= rx_data;
          state  <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (bad_len) begin
            load_error <= 1'b1;
            state      <= S_HDR;
          end else begin
            len   <= CW'(frame_len);
            state <= S_D_HI;
          end
        end
        S_D_HI: begin
          data_hi <= rx_data;
`ifdef FIFTH_LOADER_CHECKSUM_EN
          csum    <= csum + rx_data;
`endif
          state   <= S_D_LO;
        end
        S_D_LO: begin
          waddr <= waddr + 1'b1;
          wcnt  <= wcnt_nxt;
`ifdef FIFTH_LOADER_CHECKSUM_EN
          csum  <= csum + rx_data;
          state <= last_word ? S_CHK : S_D_HI;
`else
          if (last_word) begin
            state   <= S_RUN;
            running <= 1'b1;
          end else begin
            state <= S_D_HI;
          end
`endif
        end
`ifdef FIFTH_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == csum) begin
            state   <= S_RUN;
            running <= 1'b1;
          end else begin
            load_error <= 1'b1;
            state      <= S_HDR;
          end
        end
`endif
        default: state <= S_HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_fifth_code_loader.sv
// Directed + randomized bench for fifth_code_loader. Expected memory contents
// and status are kept in a frame-level model (array of written words plus the
// expected outcome of each frame computed from its length and checksum).
module tb_fifth_code_loader;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic [ADDR_W-1:0] code_addr = '0;
  logic [15:0]       instruction;
  logic              cpu_reset_n;
  logic              load_done;
  logic              load_error;

  fifth_code_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .code_addr(code_addr),
    .instruction(instruction), .cpu_reset_n(cpu_reset_n),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  bit toggle = 1'b0;
  logic [15:0] model_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the byte transfers on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    if (toggle) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    if (!rx_ready) begin
      for (int k = 0; k < 20 && !rx_ready; k++) @(negedge clk);
      if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  // Sends a whole frame and checks its outcome. Data words of a legal-length
  // frame land at addresses 0.. whether or not the checksum matches.
  task automatic send_frame(input logic [15:0] w[$], input logic [15:0] n, input bit bad_chk);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    bit len_ok;
    bit good;
    len_ok = (n != 0) && (int'(n) <= DEPTH);
    sum = 8'h00;
    bytes = {8'hA5, n[15:8], n[7:0]};
    foreach (w[i]) begin
      bytes.push_back(w[i][15:8]);
      bytes.push_back(w[i][7:0]);
      sum = sum + w[i][15:8] + w[i][7:0];
    end
`ifdef FIFTH_LOADER_CHECKSUM_EN
    if (len_ok) bytes.push_back(bad_chk ? ~sum : sum);
    good = len_ok && !bad_chk;
`else
    good = len_ok;
`endif
    for (int i = 0; i < bytes.size() - 1; i++) send_byte(bytes[i]);
    chk("done_before_last", load_done, 0);
    send_byte(bytes[bytes.size() - 1]);
    rx_valid = 1'b0;
    if (len_ok) foreach (w[i]) model_mem[i] = w[i];
    chk("load_done", load_done, good);
    chk("cpu_reset_n", cpu_reset_n, good);
    chk("load_error", load_error, !good);
  endtask

  task automatic read_check(input int addr);
    code_addr = ADDR_W'(addr);
    @(negedge clk);
    chk("instruction", instruction, model_mem[addr]);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    #1 chk("rx_ready_in_reload", rx_ready, 0);
    @(negedge clk);
    chk("reload_cpu_reset_n", cpu_reset_n, 0);
    chk("reload_load_done", load_done, 0);
    reload = 1'b0;
    #1 chk("rx_ready_after_reload", rx_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wq[$];
    logic [7:0] g;
    int n;

    // Reset values
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_cpu_reset_n", cpu_reset_n, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
    chk("rst_instruction", instruction, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Garbage then the reference frame, with rx_valid toggling
    toggle = 1'b1;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    rx_valid = 1'b0;
    chk("garbage_no_error", load_error, 0);
    wq = {16'h1234, 16'hABCD};
    send_frame(wq, 16'd2, 1'b0);
    toggle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_valid = k[0];
      #1 chk("rx_ready_run", rx_ready, 0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    read_check(0);
    read_check(1);
    do_reload();

`ifdef FIFTH_LOADER_CHECKSUM_EN
    // Bad checksum: words written, error set, then cleared by a new header
    wq = {16'h1111, 16'h2222};
    send_frame(wq, 16'd2, 1'b1);
    read_check(1);
    send_byte(8'hA5);
    rx_valid = 1'b0;
    chk("hdr_clears_error", load_error, 0);
    do_reload();
`endif

    // Length bounds
    wq = {};
    send_frame(wq, 16'h0000, 1'b0);
    send_frame(wq, 16'h2001, 1'b0);

    // Randomized frames with garbage prefixes and random back-pressure
    for (int it = 0; it < 4; it++) begin
      toggle = $urandom_range(0, 1);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      n = $urandom_range(1, 16);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      send_frame(wq, 16'(n), 1'b0);
      for (int i = 0; i < n; i++) read_check(i);
      do_reload();
    end
    toggle = 1'b0;

    // Reload aborts a frame mid-data; written words stay
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hC0); send_byte(8'h01); send_byte(8'hC0); send_byte(8'h02);
    send_byte(8'h77);
    rx_valid = 1'b0;
    model_mem[0] = 16'hC001;
    model_mem[1] = 16'hC002;
    do_reload();
    chk("abort_error_kept", load_error, 0);
    read_check(0);
    read_check(1);

    // Full-depth frame: last word at the top address, no wrap
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back(16'($urandom));
    send_frame(wq, 16'h2000, 1'b0);
    read_check(0);
    read_check(1);
    read_check(DEPTH / 2);
    read_check(DEPTH - 1);
    do_reload();

    // Async reset while in D_HI
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h13); send_byte(8'h57);
    rx_valid = 1'b0;
    model_mem[0] = 16'h1357;
    code_addr = '0;
    @(negedge clk);
    chk("pre_reset_instruction", instruction, 16'h1357);
    #2 reset = 1'b0;
    #1;
    chk("async_instruction", instruction, 16'h0000);
    chk("async_load_done", load_done, 0);
    chk("async_cpu_reset_n", cpu_reset_n, 0);
    chk("async_load_error", load_error, 0);
    chk("async_rx_ready", rx_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    read_check(0);
    read_check(DEPTH - 1);

    // Single-word frame BEEF
    wq = {16'hBEEF};
    send_frame(wq, 16'd1, 1'b0);
    read_check(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
